// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared types and constants for the register-bank operand-fetch slice.
//   XLEN        : register data width
//   REG_ADDR_W  : register address width
//   NREG        : number of architectural integer registers
//   ZERO_REG    : hardwired-zero register address (x0)
//   operand_bundle_t : registered {rs_1_data, rs_2_data} output bundle
// No ports (package).
// -----------------------------------------------------------------------------
package reg_bank_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NREG       = 32;

   typedef logic [XLEN-1:0]       xlen_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

   typedef struct packed {
      xlen_t rs_1_data;
      xlen_t rs_2_data;
   } operand_bundle_t;

   // True for every register that holds state (anything other than x0).
   function automatic logic is_arch_reg(input reg_addr_t addr);
      return (addr != ZERO_REG);
   endfunction

endpackage

// File: rtl/reg_bank_operand_file_if.sv
// -----------------------------------------------------------------------------
// reg_bank_operand_file_if
// Bundles the issue request, operand output handshake, writeback bus and
// scoreboard visibility of the operand-fetch stage.
//   master : upstream issue logic / writeback source / operand consumer
//   slave  : the reg_bank_operand_file stage
// Signals:
//   iss_valid/iss_ready           issue handshake
//   rs_1/rs_2/rd _addr, _used     instruction register fields
//   op_valid/op_ready             operand bundle handshake
//   rs_1_data/rs_2_data           operand values
//   wb_valid/wb_addr/wb_data      writeback port
//   busy_vec                      scoreboard bits (bit 0 always 0)
// -----------------------------------------------------------------------------
interface reg_bank_operand_file_if;
   import reg_bank_pkg::*;

   logic      iss_valid;
   logic      iss_ready;
   reg_addr_t rs_1_addr;
   reg_addr_t rs_2_addr;
   reg_addr_t rd_addr;
   logic      rs_1_used;
   logic      rs_2_used;
   logic      rd_used;
   logic      op_valid;
   logic      op_ready;
   xlen_t     rs_1_data;
   xlen_t     rs_2_data;
   logic      wb_valid;
   reg_addr_t wb_addr;
   xlen_t     wb_data;
   logic [NREG-1:0] busy_vec;

   modport master (
      output iss_valid, rs_1_addr, rs_2_addr, rd_addr,
             rs_1_used, rs_2_used, rd_used, op_ready,
             wb_valid, wb_addr, wb_data,
      input  iss_ready, op_valid, rs_1_data, rs_2_data, busy_vec
   );

   modport slave (
      input  iss_valid, rs_1_addr, rs_2_addr, rd_addr,
             rs_1_used, rs_2_used, rd_used, op_ready,
             wb_valid, wb_addr, wb_data,
      output iss_ready, op_valid, rs_1_data, rs_2_data, busy_vec
   );

endinterface

// File: rtl/reg_bank_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_bank_scoreboard
// One busy bit per register marking an outstanding writeback. Produces the
// RAW/WAW hazard for the instruction currently presented for issue.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   issue_i                  issue handshake fires this cycle
//   rs_1/rs_2 _used_i/_addr_i/_byp_i   source fields and bypass hits
//   rd_used_i, rd_addr_i     destination field
//   wb_valid_i, wb_addr_i    writeback clearing a busy bit
//   hazard_o                 issue must stall
//   busy_vec_o               current busy bits (bit 0 always 0)
// -----------------------------------------------------------------------------
module reg_bank_scoreboard
   import reg_bank_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            issue_i,
   input  logic            rs_1_used_i,
   input  reg_addr_t       rs_1_addr_i,
   input  logic            rs_1_byp_i,
   input  logic            rs_2_used_i,
   input  reg_addr_t       rs_2_addr_i,
   input  logic            rs_2_byp_i,
   input  logic            rd_used_i,
   input  reg_addr_t       rd_addr_i,
   input  logic            wb_valid_i,
   input  reg_addr_t       wb_addr_i,
   output logic            hazard_o,
   output logic [NREG-1:0] busy_vec_o
);

   localparam logic [NREG-1:0] ONE_HOT_0 = {{(NREG-1){1'b0}}, 1'b1};

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] set_mask_s;
   logic [NREG-1:0] clr_mask_s;

   // Busy-bit next state: clear on writeback, then set on issue so set wins.
   always_comb begin
      clr_mask_s = (wb_valid_i && is_arch_reg(wb_addr_i))
                   ? (ONE_HOT_0 << wb_addr_i) : {NREG{1'b0}};
      set_mask_s = (issue_i && rd_used_i && is_arch_reg(rd_addr_i))
                   ? (ONE_HOT_0 << rd_addr_i) : {NREG{1'b0}};
      // x0 can never become busy.
      busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT_0;
   end

   // Busy-bit register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= {NREG{1'b0}};
      end else begin
         busy_q <= busy_d;
      end
   end

   // Hazard: a source waits unless the same-cycle writeback feeds it; the
   // destination waits regardless (one outstanding write per register).
   always_comb begin
      hazard_o = (rs_1_used_i && busy_q[rs_1_addr_i] && !rs_1_byp_i) ||
                 (rs_2_used_i && busy_q[rs_2_addr_i] && !rs_2_byp_i) ||
                 (rd_used_i   && busy_q[rd_addr_i]);
   end

   assign busy_vec_o = busy_q;

endmodule

// File: rtl/reg_bank_operand_file.sv
// -----------------------------------------------------------------------------
// reg_bank_operand_file
// 32 x XLEN architectural register file (x0 reads zero) with busy-bit
// scoreboard and a registered valid/ready operand output stage.
// Ports:
//   reg_clk  clock, all state on rising edge
//   reg_rst  synchronous active-high reset
//   rb_if    reg_bank_operand_file_if.slave (issue, operands, writeback,
//            busy_vec)
// Configuration macro:
//   REG_BANK_WB_BYPASS_EN  when defined, a same-cycle writeback forwards
//                          wb_data to a matching source and cancels its RAW
//                          stall; when undefined, operands come from the
//                          array only.
// -----------------------------------------------------------------------------
module reg_bank_operand_file
   import reg_bank_pkg::*;
(
   input  logic                   reg_clk,
   input  logic                   reg_rst,
   reg_bank_operand_file_if.slave rb_if
);

   xlen_t           regs_q [NREG];
   operand_bundle_t bundle_q;
   operand_bundle_t bundle_d;
   logic            op_valid_q;
   logic            op_valid_d;

   logic            byp_1_s;
   logic            byp_2_s;
   logic            hazard_s;
   logic            iss_ready_s;
   logic            issue_s;
   logic            wr_en_s;
   xlen_t           src_1_s;
   xlen_t           src_2_s;
   logic [NREG-1:0] busy_vec_s;

`ifdef REG_BANK_WB_BYPASS_EN
   assign byp_1_s = rb_if.wb_valid && (rb_if.wb_addr == rb_if.rs_1_addr) &&
                    is_arch_reg(rb_if.wb_addr);
   assign byp_2_s = rb_if.wb_valid && (rb_if.wb_addr == rb_if.rs_2_addr) &&
                    is_arch_reg(rb_if.wb_addr);
`else
   assign byp_1_s = 1'b0;
   assign byp_2_s = 1'b0;
`endif

   assign wr_en_s     = rb_if.wb_valid && is_arch_reg(rb_if.wb_addr);
   // No path from op_ready to op_valid: op_ready only gates acceptance here.
   assign iss_ready_s = !hazard_s && (!op_valid_q || rb_if.op_ready);
   assign issue_s     = rb_if.iss_valid && iss_ready_s;

   reg_bank_scoreboard u_scoreboard (
      .clk_i       (reg_clk),
      .rst_i       (reg_rst),
      .issue_i     (issue_s),
      .rs_1_used_i (rb_if.rs_1_used),
      .rs_1_addr_i (rb_if.rs_1_addr),
      .rs_1_byp_i  (byp_1_s),
      .rs_2_used_i (rb_if.rs_2_used),
      .rs_2_addr_i (rb_if.rs_2_addr),
      .rs_2_byp_i  (byp_2_s),
      .rd_used_i   (rb_if.rd_used),
      .rd_addr_i   (rb_if.rd_addr),
      .wb_valid_i  (rb_if.wb_valid),
      .wb_addr_i   (rb_if.wb_addr),
      .hazard_o    (hazard_s),
      .busy_vec_o  (busy_vec_s)
   );

   // Operand select: unused field or x0 gives 0, else bypass or array.
   always_comb begin
      src_1_s = (!rb_if.rs_1_used || !is_arch_reg(rb_if.rs_1_addr)) ? {XLEN{1'b0}}
              : (byp_1_s ? rb_if.wb_data : regs_q[rb_if.rs_1_addr]);
      src_2_s = (!rb_if.rs_2_used || !is_arch_reg(rb_if.rs_2_addr)) ? {XLEN{1'b0}}
              : (byp_2_s ? rb_if.wb_data : regs_q[rb_if.rs_2_addr]);
   end

   // Output stage next state: load on issue, drop valid on consume, else hold.
   always_comb begin
      bundle_d   = bundle_q;
      op_valid_d = op_valid_q;
      if (issue_s) begin
         op_valid_d         = 1'b1;
         bundle_d.rs_1_data = src_1_s;
         bundle_d.rs_2_data = src_2_s;
      end else if (rb_if.op_ready) begin
         op_valid_d = 1'b0;
      end else begin
         op_valid_d = op_valid_q;
      end
   end

   // Output stage registers.
   always_ff @(posedge reg_clk) begin
      if (reg_rst) begin
         op_valid_q <= 1'b0;
         bundle_q   <= '{rs_1_data: {XLEN{1'b0}}, rs_2_data: {XLEN{1'b0}}};
      end else begin
         op_valid_q <= op_valid_d;
         bundle_q   <= bundle_d;
      end
   end

   // Register array; x0 is never written so it stays zero.
   always_ff @(posedge reg_clk) begin
      if (reg_rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {XLEN{1'b0}};
         end
      end else if (wr_en_s) begin
         regs_q[rb_if.wb_addr] <= rb_if.wb_data;
      end
   end

   assign rb_if.iss_ready = iss_ready_s;
   assign rb_if.op_valid  = op_valid_q;
   assign rb_if.rs_1_data = bundle_q.rs_1_data;
   assign rb_if.rs_2_data = bundle_q.rs_2_data;
   assign rb_if.busy_vec  = busy_vec_s;

endmodule
